// File: rtl/csit_luks_keypad.sv
// Rotary/pushbutton 4-digit hex code entry with a muxed seven-segment display and an SPI sender.
// Optional macro FLASH_LOG_EN: each luks frame is followed by a 24-bit A5+code frame on the flash select.
module csit_luks_keypad #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 5000000,
  parameter int MUX_DIV           = 1024,
  parameter int SPI_DIV           = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int MX_W = $clog2(MUX_DIV + 1);
  localparam int SD_W = $clog2(SPI_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SHIFT, S_DEASSERT} spi_state_t;

  logic rst;
  assign rst = rst_n;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Synchroniser; the button flops reset to the released (high) level.
  logic [2:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b100;
      sync2 <= 3'b100;
    end else begin
      sync1 <= ui_in[2:0];
      sync2 <= sync1;
    end
  end

  // Encoder: detent pulses on entering 00; 11->00 is a two-bit jump and never counts.
  logic [1:0] enc_q, ab;
  logic       det_inc, det_dec;
  assign ab = sync2[1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q   <= 2'b00;
      det_inc <= 1'b0;
      det_dec <= 1'b0;
    end else begin
      det_inc <= 1'b0;
      det_dec <= 1'b0;
      if (ab != enc_q) begin
        enc_q <= ab;
        if (ab == 2'b00 && enc_q == 2'b10) det_inc <= 1'b1;
        if (ab == 2'b00 && enc_q == 2'b01) det_dec <= 1'b1;
      end
    end
  end

  logic [15:0] code;
  logic [1:0]  cursor;
  logic [1:0]  press_type;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code   <= 16'h0000;
      cursor <= 2'd0;
    end else begin
      if (det_inc || det_dec)
        code[{cursor, 2'b00} +: 4] <= code[{cursor, 2'b00} +: 4] + (det_inc ? 4'h1 : 4'hF);
      if (press_type == 2'd1) cursor <= cursor + 2'd1;
    end
  end

  // Debounce: counter runs only while the raw level differs from the accepted one.
  logic            btn_raw, btn_db, btn_db_q;
  logic [DB_W-1:0] db_cnt;
  assign btn_raw = ~sync2[2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_raw == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_raw;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  spi_state_t spi_state, spi_next;
  logic       busy, start_luks, start_flash;
  logic [LP_W-1:0] press_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_q   <= 1'b0;
      press_cnt  <= '0;
      press_type <= 2'd0;
    end else begin
      btn_db_q   <= btn_db;
      press_type <= 2'd0;
      if (btn_db && !btn_db_q)
        press_cnt <= '0;
      else if (btn_db && press_cnt != LP_W'(LONG_PRESS_CYCLES))
        press_cnt <= press_cnt + LP_W'(1);
      if (!btn_db && btn_db_q && !busy)
        press_type <= (press_cnt >= LP_W'(LONG_PRESS_CYCLES)) ? 2'd2 : 2'd1;
    end
  end
  assign start_luks = (press_type == 2'd2);

  // Display scan: outputs are registered so they are clean (blank) straight out of reset.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  logic [MX_W-1:0] mux_cnt;
  logic [1:0]      digit_idx;
  logic [3:0]      dig_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_cnt   <= '0;
      digit_idx <= 2'd0;
      uo_out    <= 8'hFF;
      dig_n     <= 4'b1111;
    end else begin
      if (mux_cnt == MX_W'(MUX_DIV - 1)) begin
        mux_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        mux_cnt <= mux_cnt + MX_W'(1);
      end
      uo_out <= {(digit_idx != cursor), hex_seg(code[{digit_idx, 2'b00} +: 4])};
      dig_n  <= ~(4'b0001 << digit_idx);
    end
  end

  // SPI master, mode 0 MSB first. sh is left-aligned so bit 23 is always the bit on MOSI.
  logic [SD_W-1:0] div_cnt;
  logic            div_last, sclk_hi, tgt_flash;
  logic [4:0]      bit_cnt, frame_last;
  logic [23:0]     sh;
  logic [15:0]     code_snap;
  logic            sclk, ss_luks_n, ss_flash_n, mosi;

  assign div_last = (div_cnt == SD_W'(SPI_DIV - 1));
  assign busy     = (spi_state != S_IDLE) || start_flash;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spi_state <= S_IDLE;
    else     spi_state <= spi_next;
  end

  always_comb begin
    spi_next = spi_state;
    case (spi_state)
      S_IDLE:     if (start_luks || start_flash) spi_next = S_ASSERT;
      S_ASSERT:   if (div_last) spi_next = S_SHIFT;
      S_SHIFT:    if (div_last && !sclk_hi && bit_cnt == frame_last) spi_next = S_DEASSERT;
      S_DEASSERT: if (div_last) spi_next = S_IDLE;
      default:    spi_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      sclk_hi    <= 1'b0;
      bit_cnt    <= 5'd0;
      frame_last <= 5'd0;
      sh         <= 24'h0;
      tgt_flash  <= 1'b0;
      code_snap  <= 16'h0;
    end else if (spi_state == S_IDLE) begin
      div_cnt <= '0;
      sclk_hi <= 1'b0;
      bit_cnt <= 5'd0;
      if (start_luks) begin
        sh         <= {code, 8'h00};
        code_snap  <= code;
        frame_last <= 5'd15;
        tgt_flash  <= 1'b0;
      end else if (start_flash) begin
        sh         <= {8'hA5, code_snap};
        frame_last <= 5'd23;
        tgt_flash  <= 1'b1;
      end
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + SD_W'(1);
      if (spi_state == S_ASSERT && div_last) sclk_hi <= 1'b1;
      if (spi_state == S_SHIFT && div_last) begin
        sclk_hi <= ~sclk_hi;
        if (sclk_hi) sh <= {sh[22:0], 1'b0};
        else         bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

`ifdef FLASH_LOG_EN
  logic flash_pend;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flash_pend <= 1'b0;
    else if (spi_state == S_DEASSERT && div_last && !tgt_flash)
      flash_pend <= 1'b1;
    else if (spi_state == S_IDLE)
      flash_pend <= 1'b0;
  end
  assign start_flash = flash_pend;
`else
  assign start_flash = 1'b0;
`endif

  always_comb begin
    sclk       = (spi_state == S_SHIFT) && sclk_hi;
    ss_luks_n  = !((spi_state != S_IDLE) && !tgt_flash);
    ss_flash_n = !((spi_state != S_IDLE) && tgt_flash);
    mosi       = (spi_state != S_IDLE) && sh[23];
  end

  assign uio_out = {mosi, ss_luks_n, ss_flash_n, sclk, dig_n};
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_csit_luks_keypad.sv
// Directed bench for csit_luks_keypad: display scan, encoder table, button classes, SPI frames, reset abort.
module tb_csit_luks_keypad;
  localparam int MUX = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  csit_luks_keypad #(
    .DEBOUNCE_CYCLES(16), .LONG_PRESS_CYCLES(200), .MUX_DIV(MUX), .SPI_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // SPI capture on SCLK rising edges, sampled on the inactive clock edge.
  logic        prev_sclk = 1'b0, prev_ssl = 1'b1, prev_ssf = 1'b1;
  logic [15:0] luks_bits = 16'h0;
  logic [23:0] flash_bits = 24'h0;
  int          luks_cnt = 0, flash_cnt = 0;
  logic        flash_seen_low = 1'b0;

  always @(negedge clk) begin
    prev_sclk <= uio_out[4];
    prev_ssl  <= uio_out[6];
    prev_ssf  <= uio_out[5];
    if (prev_ssl && !uio_out[6]) begin
      luks_cnt  <= 0;
      luks_bits <= 16'h0;
    end else if (!prev_sclk && uio_out[4] && !uio_out[6]) begin
      luks_bits <= {luks_bits[14:0], uio_out[7]};
      luks_cnt  <= luks_cnt + 1;
    end
    if (prev_ssf && !uio_out[5]) begin
      flash_cnt  <= 0;
      flash_bits <= 24'h0;
    end else if (!prev_sclk && uio_out[4] && !uio_out[5]) begin
      flash_bits <= {flash_bits[22:0], uio_out[7]};
      flash_cnt  <= flash_cnt + 1;
    end
    if (rst_n == 1'b0 && !uio_out[5]) flash_seen_low <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_digit(input int i, input string name, input logic [7:0] exp);
    logic [3:0] want;
    logic [7:0] seg;
    logic       hit;
    want = ~(4'b0001 << i);
    hit  = 1'b0;
    seg  = 8'hxx;
    for (int k = 0; k < 4 * MUX + 8 && !hit; k++) begin
      @(negedge clk);
      if (uio_out[3:0] == want) begin
        hit = 1'b1;
        seg = uo_out;
      end
    end
    check({name, "_scan"}, 32'(hit), 32'd1);
    if (hit) check(name, 32'(seg), 32'(exp));
  endtask

  task automatic wait_pin(input int bitn, input logic val, input int budget, input string name);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      if (uio_out[bitn] == val) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic press(input int hold);
    ui_in[2] = 1'b0;
    cycles(hold);
    ui_in[2] = 1'b1;
  endtask

  typedef struct {
    logic [1:0] ba;
    logic [7:0] exp_d0;
  } enc_vec_t;
  enc_vec_t vecs[20];

  initial begin
    logic [3:0] exp_en, prev_en;
    logic       hit;

    // {B,A} step and expected digit-0 output (cursor on digit 0, so dp low).
    vecs[0]  = '{2'b01, 8'h40}; vecs[1]  = '{2'b11, 8'h40};
    vecs[2]  = '{2'b10, 8'h40}; vecs[3]  = '{2'b00, 8'h79};
    vecs[4]  = '{2'b01, 8'h79}; vecs[5]  = '{2'b00, 8'h40};
    vecs[6]  = '{2'b10, 8'h40}; vecs[7]  = '{2'b11, 8'h40};
    vecs[8]  = '{2'b01, 8'h40}; vecs[9]  = '{2'b00, 8'h0E};
    vecs[10] = '{2'b01, 8'h0E}; vecs[11] = '{2'b11, 8'h0E};
    vecs[12] = '{2'b10, 8'h0E}; vecs[13] = '{2'b00, 8'h40};
    vecs[14] = '{2'b01, 8'h40}; vecs[15] = '{2'b11, 8'h40};
    vecs[16] = '{2'b10, 8'h40}; vecs[17] = '{2'b00, 8'h79};
    vecs[18] = '{2'b11, 8'h79}; vecs[19] = '{2'b00, 8'h79};

    rst_n  = 1'b1;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'b0000_0100;
    cycles(3);
    check("rst_uo_out", 32'(uo_out), 32'hFF);
    check("rst_uio_out", 32'(uio_out), 32'h6F);
    check("rst_uio_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;

    // Scan order and idle display.
    read_digit(0, "idle_d0", 8'h40);
    prev_en = uio_out[3:0];
    for (int j = 1; j <= 4; j++) begin
      exp_en = ~(4'b0001 << (j % 4));
      hit = 1'b0;
      for (int k = 0; k < MUX + 4 && !hit; k++) begin
        @(negedge clk);
        if (uio_out[3:0] != prev_en) hit = 1'b1;
      end
      check("scan_step", 32'(uio_out[3:0]), 32'(exp_en));
      if (j < 4) check("idle_dx", 32'(uo_out), 32'hC0);
      prev_en = uio_out[3:0];
    end
    check("idle_ss", 32'(uio_out[6:5]), 32'h3);

    // Encoder table.
    for (int v = 0; v < 20; v++) begin
      ui_in[1:0] = vecs[v].ba;
      cycles(100);
      read_digit(0, $sformatf("enc_%0d", v), vecs[v].exp_d0);
    end

    // Short press moves the cursor; CCW detent edits digit 1 to F.
    press(100);
    cycles(100);
    read_digit(1, "short_d1", 8'h40);
    read_digit(0, "short_d0", 8'hF9);
    ui_in[1:0] = 2'b10; cycles(100);
    ui_in[1:0] = 2'b11; cycles(100);
    ui_in[1:0] = 2'b01; cycles(100);
    ui_in[1:0] = 2'b00; cycles(100);
    read_digit(1, "ccw_d1", 8'h0E);

    // Bounce faster than the debounce window: no cursor move.
    for (int b = 0; b < 20; b++) begin
      ui_in[2] = ~ui_in[2];
      cycles(5);
    end
    ui_in[2] = 1'b1;
    cycles(60);
    read_digit(1, "bounce_d1", 8'h0E);
    read_digit(2, "bounce_d2", 8'hC0);

    // Long press sends code 00F1; a press inside the frame is discarded.
    press(300);
    wait_pin(6, 1'b0, 200, "luks_ss_low");
    press(30);
    wait_pin(6, 1'b1, 300, "luks_ss_high");
    cycles(1);
    check("luks_edges", 32'(luks_cnt), 32'd16);
    check("luks_data", 32'(luks_bits), 32'h00F1);
`ifdef FLASH_LOG_EN
    wait_pin(5, 1'b0, 20, "flash_ss_low");
    wait_pin(5, 1'b1, 400, "flash_ss_high");
    cycles(1);
    check("flash_edges", 32'(flash_cnt), 32'd24);
    check("flash_data", 32'(flash_bits), 32'hA500F1);
`else
    cycles(50);
    check("flash_idle", 32'(flash_seen_low), 32'd0);
`endif
    check("idle_sclk_mosi", 32'({uio_out[7], uio_out[4]}), 32'd0);
    cycles(100);
    read_digit(1, "frame_press_d1", 8'h0E);
    read_digit(0, "frame_press_d0", 8'hF9);

    // Reset mid-frame aborts at once.
    press(300);
    wait_pin(6, 1'b0, 200, "abort_ss_low");
    cycles(40);
    rst_n = 1'b1;
    #1;
    check("abort_uo_out", 32'(uo_out), 32'hFF);
    check("abort_uio_out", 32'(uio_out), 32'h6F);
    check("abort_uio_oe", 32'(uio_oe), 32'hFF);
    cycles(3);
    rst_n = 1'b0;
    read_digit(0, "abort_d0", 8'h40);
    read_digit(1, "abort_d1", 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
